// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX byte port among NUM_REQ requesters.
// Define UART_ARB_STATS_EN to add per-requester transferred-byte counters and the stat_* ports.
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 3,
    parameter int          IDLE_TIMEOUT = 1024,
    parameter logic [7:0]  EOL_BYTE     = 8'h0A
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_valid_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_ready_i,
    output logic [NUM_REQ-1:0]         grant_o,
`ifdef UART_ARB_STATS_EN
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel_i,
    output logic [31:0]                stat_cnt_o,
`endif
    output logic [$clog2(NUM_REQ)-1:0] owner_o
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    // Handshake: a byte moves on any cycle where tx_valid_o && tx_ready_i; valid
    // never waits on ready, and only the current owner ever sees req_ready_o.
    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [OW-1:0]   pick_idx;
    logic            pick_found;
    int              cand;
    logic            locked;
    logic            owner_valid;
    logic [7:0]      owner_byte;
    logic            xfer;
    logic            release_now;

    assign locked      = (state_q == S_LOCKED);
    assign owner_valid = locked && req_valid_i[owner_q];
    assign owner_byte  = req_data_i[{owner_q, 3'b000} +: 8];
    assign xfer        = owner_valid && tx_ready_i;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && req_valid_i[OW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(cand);
            end
        end
    end

    always_comb begin
        tx_valid_o  = owner_valid;
        tx_data_o   = owner_valid ? owner_byte : 8'h00;
        req_ready_o = '0;
        grant_o     = '0;
        if (locked) begin
            req_ready_o[owner_q] = tx_ready_i;
            grant_o[owner_q]     = 1'b1;
        end
    end

    assign owner_o = owner_q;

    assign release_now = (xfer && (owner_byte == EOL_BYTE)) ||
                         (!owner_valid && (idle_cnt_q == CW'(IDLE_TIMEOUT - 1)));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d    = S_LOCKED;
                    owner_d    = pick_idx;
                    idle_cnt_d = '0;
                end
            end
            S_LOCKED: begin
                if (owner_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != CW'(IDLE_TIMEOUT)) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (release_now) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [31:0] stat_q [NUM_REQ];
    logic [31:0] stat_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                stat_q[k] <= '0;
            end
            stat_cnt_q <= '0;
        end else begin
            if (xfer) begin
                stat_q[owner_q] <= stat_q[owner_q] + 32'd1;
            end
            // Out-of-range selects read as zero for non-power-of-two NUM_REQ.
            stat_cnt_q <= (int'(stat_sel_i) < NUM_REQ) ? stat_q[stat_sel_i] : 32'd0;
        end
    end

    assign stat_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=3, IDLE_TIMEOUT=16); covers UART_ARB_STATS_EN when defined.
module tb_uart_tx_arbiter;

    localparam int NR = 3;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic [NR-1:0] grant;
    logic [1:0]    owner;
`ifdef UART_ARB_STATS_EN
    logic [1:0]    stat_sel;
    logic [31:0]   stat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Per-requester message driver state.
    logic [7:0] msg_mem [NR][8];
    int         msg_len [NR];
    int         msg_ptr [NR];
    int         msg_start [NR];

    // Observed transfers and scoreboard expectations.
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [1:0] got_own_q[$];
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .IDLE_TIMEOUT (16),
        .EOL_BYTE     (8'h0A)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
`ifdef UART_ARB_STATS_EN
        .stat_sel_i  (stat_sel),
        .stat_cnt_o  (stat_cnt),
`endif
        .owner_o     (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int k, input logic v, input logic [7:0] d);
        req_valid[k]       = v;
        req_data[k*8 +: 8] = d;
    endtask

    task automatic load_msg(input int k, input string s, input int start);
        for (int i = 0; i < s.len(); i++) begin
            msg_mem[k][i] = s[i];
        end
        msg_len[k]   = s.len();
        msg_ptr[k]   = 0;
        msg_start[k] = start;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        for (int k = 0; k < NR; k++) begin
            msg_len[k]   = 0;
            msg_ptr[k]   = 0;
            msg_start[k] = 0;
        end
        got_q.delete();
        got_cyc_q.delete();
        got_own_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive every requester from its message, then log any TX transfer.
    task automatic drive_cycle(input int cyc, input logic rdy);
        @(negedge clk);
        tx_ready = rdy;
        for (int k = 0; k < NR; k++) begin
            if (cyc >= msg_start[k] && msg_ptr[k] < msg_len[k]) begin
                set_req(k, 1'b1, msg_mem[k][msg_ptr[k]]);
            end else begin
                set_req(k, 1'b0, 8'h00);
            end
        end
        #1;
        if (tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            got_cyc_q.push_back(cyc);
            got_own_q.push_back(owner);
        end
        for (int k = 0; k < NR; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                msg_ptr[k]++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        req_data  = 24'hAABBCC;
        tx_ready  = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant: got %b expected 000", grant); end
        checks++;
        if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++;
        if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++;
        if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
        req_valid = '0;
        req_data  = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single_hi();
        logic [2:0] exp_g;
        do_reset();
        load_msg(1, "hi\nz\n", 0);
        exp_q     = '{8'h68, 8'h69, 8'h0A, 8'h7A, 8'h0A};
        exp_cyc_q = '{1, 2, 3, 5, 6};
        for (int c = 0; c < 8; c++) begin
            drive_cycle(c, 1'b1);
            exp_g = (c >= 1 && c <= 3) || (c >= 5 && c <= 6) ? 3'b010 : 3'b000;
            checks++;
            if (grant !== exp_g) begin failures++; $display("FAIL single_grant c%0d: got %b expected %b", c, grant, exp_g); end
            if (c == 4) begin
                checks++;
                if (owner !== 2'd1) begin failures++; $display("FAIL single_last_owner: got %0d expected 1", owner); end
                checks++;
                if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_dead_tx_valid: got %b expected 0", tx_valid); end
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
                failures++;
                $display("FAIL single_byte%0d: got %h@c%0d expected %h@c%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_own[$];
        do_reset();
        load_msg(0, "A\n", 0);
        load_msg(1, "B\n", 0);
        load_msg(2, "C\n", 0);
        exp_q     = '{8'h41, 8'h0A, 8'h42, 8'h0A, 8'h43, 8'h0A};
        exp_cyc_q = '{1, 2, 4, 5, 7, 8};
        exp_own   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c, 1'b1);
            if (c == 1) begin
                checks++;
                if (req_ready !== 3'b001) begin failures++; $display("FAIL rr_nonowner_ready: got %b expected 001", req_ready); end
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i] || got_own_q[i] !== exp_own[i]) begin
                failures++;
                $display("FAIL rr_byte%0d: got %h@c%0d own%0d expected %h@c%0d own%0d",
                         i, got_q[i], got_cyc_q[i], got_own_q[i], exp_q[i], exp_cyc_q[i], exp_own[i]);
            end
        end
`ifdef UART_ARB_STATS_EN
        stat_sel = 2'd1;
`endif
        // Pointer must be back at 0: requesters 0 and 1 contend, 0 wins.
        load_msg(0, "p\n", 10);
        load_msg(1, "q\n", 10);
        drive_cycle(10, 1'b1);
`ifdef UART_ARB_STATS_EN
        checks++;
        if (stat_cnt !== 32'd2) begin failures++; $display("FAIL stat_cnt_req1: got %0d expected 2", stat_cnt); end
`endif
        drive_cycle(11, 1'b1);
        checks++;
        if (grant !== 3'b001) begin failures++; $display("FAIL rr_wrap_grant: got %b expected 001", grant); end
        checks++;
        if (tx_data !== 8'h70) begin failures++; $display("FAIL rr_wrap_data: got %h expected 70", tx_data); end
    endtask

    task automatic test_timeout();
        logic [2:0] exp_g;
        do_reset();
        load_msg(2, "x", 0);
        load_msg(0, "p\n", 1);
        exp_q     = '{8'h78, 8'h70, 8'h0A};
        exp_cyc_q = '{1, 19, 20};
        for (int c = 0; c < 22; c++) begin
            drive_cycle(c, 1'b1);
            if (c == 0 || c == 18 || c == 21) exp_g = 3'b000;
            else if (c <= 17) exp_g = 3'b100;
            else exp_g = 3'b001;
            checks++;
            if (grant !== exp_g) begin failures++; $display("FAIL timeout_grant c%0d: got %b expected %b", c, grant, exp_g); end
            if (c == 17) begin
                checks++;
                if (req_ready !== 3'b100 || tx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_wait: got ready %b valid %b expected ready 100 valid 0", req_ready, tx_valid);
                end
            end
            if (c == 18) begin
                checks++;
                if (owner !== 2'd2) begin failures++; $display("FAIL timeout_last_owner: got %0d expected 2", owner); end
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL timeout_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
                failures++;
                $display("FAIL timeout_byte%0d: got %h@c%0d expected %h@c%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_timeout_edge();
        logic [2:0] exp_g;
        do_reset();
        @(negedge clk);
        tx_ready = 1'b0;
        set_req(1, 1'b1, 8'h61);
        // Owner returns exactly in the cycle the counter would expire, then goes idle again.
        for (int c = 1; c < 35; c++) begin
            @(negedge clk);
            set_req(1, (c == 16), 8'h61);
            #1;
            exp_g = (c <= 32) ? 3'b010 : 3'b000;
            checks++;
            if (grant !== exp_g) begin failures++; $display("FAIL tedge_grant c%0d: got %b expected %b", c, grant, exp_g); end
            if (c == 16) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h61) begin
                    failures++;
                    $display("FAIL tedge_valid: got %b/%h expected 1/61", tx_valid, tx_data);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        load_msg(0, "ok\n", 0);
        exp_q     = '{8'h6F, 8'h6B, 8'h0A};
        exp_cyc_q = '{1, 22, 23};
        for (int c = 0; c < 25; c++) begin
            drive_cycle(c, !(c >= 2 && c <= 21));
            if (c >= 2 && c <= 21) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h6B || req_ready !== 3'b000 || grant !== 3'b001) begin
                    failures++;
                    $display("FAIL stall c%0d: got v%b d%h r%b g%b expected v1 d6b r000 g001", c, tx_valid, tx_data, req_ready, grant);
                end
            end
        end
        checks++;
        if (grant !== 3'b000) begin failures++; $display("FAIL stall_release: got %b expected 000", grant); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_cyc_q[i] != exp_cyc_q[i]) begin
                failures++;
                $display("FAIL stall_byte%0d: got %h@c%0d expected %h@c%0d", i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_msg(1, "z\nabc\n", 0);
        for (int c = 0; c < 6; c++) begin
            drive_cycle(c, 1'b1);
            if (c == 4) begin
                checks++;
                if (grant !== 3'b010 || tx_data !== 8'h61) begin
                    failures++;
                    $display("FAIL rmid_regrant: got %b/%h expected 010/61", grant, tx_data);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        set_req(1, 1'b1, 8'h63);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 8'h30);
        set_req(1, 1'b1, 8'h63);
        set_req(2, 1'b1, 8'h32);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rmid_tx: got %b/%h expected 0/00", tx_valid, tx_data); end
        checks++;
        if (grant !== 3'b000) begin failures++; $display("FAIL rmid_grant: got %b expected 000", grant); end
        checks++;
        if (owner !== 2'd0) begin failures++; $display("FAIL rmid_owner: got %0d expected 0", owner); end
        checks++;
        if (req_ready !== 3'b000) begin failures++; $display("FAIL rmid_ready: got %b expected 000", req_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 3'b001 || owner !== 2'd0 || tx_data !== 8'h30) begin
            failures++;
            $display("FAIL rmid_rearb: got %b own%0d %h expected 001 own0 30", grant, owner, tx_data);
        end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
`ifdef UART_ARB_STATS_EN
        stat_sel  = '0;
`endif
        test_reset();
        test_single_hi();
        test_round_robin();
        test_timeout();
        test_timeout_edge();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
